// File: rtl/simd_seq_pkg.sv
// Shared widths, depth and FSM state encoding for the SIMD operand sequencer.
package simd_seq_pkg;
  localparam int DATA_W  = 128;
  localparam int DEPTH   = 64;
  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_PREFETCH,
    S_STREAM,
    S_DONE
  } seq_state_t;
endpackage

// File: rtl/simd_operand_ram.sv
// Paired opa/opb operand storage: one write port, one registered read port.
// Array contents survive reset; only the read registers are cleared.
module simd_operand_ram
  import simd_seq_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int DEP   = DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_opa,
  input  logic [DW-1:0] wr_opb,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_opa,
  output logic [DW-1:0] rd_opb
);
  logic [DW-1:0] mem_a [DEP];
  logic [DW-1:0] mem_b [DEP];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_a[wr_addr] <= wr_opa;
      mem_b[wr_addr] <= wr_opb;
    end
  end

  // Read registers double as the beat outputs, so they hold when rd_en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_opa <= '0;
      rd_opb <= '0;
    end else if (rd_en) begin
      rd_opa <= mem_a[rd_addr];
      rd_opb <= mem_b[rd_addr];
    end
  end
endmodule

// File: rtl/simd_operand_sequencer.sv
// Preloaded operand buffer streamed to simd_top_level: ISSUE, PREFETCH, size+1 beats, DONE.
// Optional SIMD_SEQ_STALL_EN adds a stall input that freezes the stream in place.
module simd_operand_sequencer
  import simd_seq_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int AW  = ADDR_W,
  parameter int IW  = INSTR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_opa,
  input  logic [DW-1:0] wr_opb,
  output logic          wr_rej,
  input  logic          start,
  input  logic [IW-1:0] start_instruction,
  input  logic [AW-1:0] start_size,
  output logic          busy,
  output logic          done,
  output logic          valid_instruction,
  output logic [IW-1:0] instruction,
  output logic [AW-1:0] data_size,
  output logic          valid_data,
`ifdef SIMD_SEQ_STALL_EN
  input  logic          stall,
`endif
  output logic [DW-1:0] mc_data_in_opa,
  output logic [DW-1:0] mc_data_in_opb
);
  seq_state_t    state;
  logic [AW-1:0] beat;
  logic          beat_vld;
  logic          hold;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

`ifdef SIMD_SEQ_STALL_EN
  assign hold       = stall && (state == S_STREAM);
  assign valid_data = beat_vld && !stall;
`else
  assign hold       = 1'b0;
  assign valid_data = beat_vld;
`endif

  // Read address runs one ahead of the beat on the bus; never issued past data_size.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = beat + AW'(1);
    if (state == S_PREFETCH) begin
      rd_en   = 1'b1;
      rd_addr = '0;
    end else if (state == S_STREAM && !hold && beat != data_size) begin
      rd_en = 1'b1;
    end
  end

  simd_operand_ram #(.DW(DW), .DEP(1 << AW), .AW(AW)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && state == S_IDLE),
    .wr_addr (wr_addr),
    .wr_opa  (wr_opa),
    .wr_opb  (wr_opb),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_opa  (mc_data_in_opa),
    .rd_opb  (mc_data_in_opb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      beat              <= '0;
      beat_vld          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      wr_rej            <= 1'b0;
      valid_instruction <= 1'b0;
      instruction       <= '0;
      data_size         <= '0;
    end else begin
      wr_rej <= wr_en && (state != S_IDLE);
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state             <= S_ISSUE;
            busy              <= 1'b1;
            valid_instruction <= 1'b1;
            instruction       <= start_instruction;
            data_size         <= start_size;
            beat              <= '0;
          end
        end
        S_ISSUE:    state <= S_PREFETCH;
        S_PREFETCH: begin
          state    <= S_STREAM;
          beat_vld <= 1'b1;
        end
        S_STREAM: begin
          if (!hold) begin
            if (beat == data_size) begin
              state             <= S_DONE;
              beat_vld          <= 1'b0;
              valid_instruction <= 1'b0;
              done              <= 1'b1;
            end else begin
              beat <= beat + AW'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
